mp_add_sequencer: RTL and testbench

- Sequences a multi-precision add (WORDS x W bits) through one shared registered W-bit adder (the 64-bit carry-select adder), one slice per cycle, least-significant slice first.
- Chains each slice's carry-out into the next slice's carry-in.
- Sits between a valid/ready requester and the adder. The adder's active-high sync reset is driven from ~reset at integration.

---
 rtl/mp_add_sequencer.sv | 133 +++++++++++++
 tb/tb_mp_add_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_sequencer.sv
// rtl/mp_add_sequencer.sv - multi-precision add sequenced through one registered W-bit adder slice per cycle.
// Optional subtract mode (req_sub port) when MP_ADD_SUB_EN is defined.
module mp_add_sequencer #(
  parameter int W     = 64,
  parameter int WORDS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [W*WORDS-1:0] req_a,
  input  logic [W*WORDS-1:0] req_b,
  input  logic               req_cin,
`ifdef MP_ADD_SUB_EN
  input  logic               req_sub,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W*WORDS-1:0] rsp_sum,
  output logic               rsp_cout,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_s,
  input  logic               add_cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [W*WORDS-1:0] opa_q, opa_d;
  logic [W*WORDS-1:0] opb_q, opb_d;
  logic               cin_q, cin_d;
  logic [W*WORDS-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          opa_d = req_a;
`ifdef MP_ADD_SUB_EN
          opb_d = req_sub ? ~req_b : req_b;
          cin_d = req_sub | req_cin;
`else
          opb_d = req_b;
          cin_d = req_cin;
`endif
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The adder output seen now belongs to the slice issued one cycle earlier.
        for (int i = 1; i < WORDS; i++) begin
          if (int'(idx_q) == i) sum_d[(i-1)*W +: W] = add_s;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        sum_d[(WORDS-1)*W +: W] = add_s;
        cout_d  = add_cout;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < WORDS; i++) begin
        if (int'(idx_q) == i) begin
          add_a = opa_q[i*W +: W];
          add_b = opb_q[i*W +: W];
        end
      end
      // Slice 0 takes the latched carry so stale adder state never leaks in.
      add_cin = (idx_q == '0) ? cin_q : add_cout;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb/tb_mp_add_sequencer.sv - randomized self-checking bench for mp_add_sequencer against a 256-bit reference model.
module tb_mp_add_sequencer;
  localparam int W     = 64;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic         clock;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         req_cin;
  logic         req_sub;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_sum;
  logic         rsp_cout;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;

  int passed = 0;
  int total  = 0;

  mp_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef MP_ADD_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout)
  );

  // Registered slice adder with active-high sync reset tied to ~reset.
  logic adder_rst;
  assign adder_rst = ~reset;
  always @(posedge clock) begin
    if (adder_rst) {add_cout, add_s} <= '0;
    else {add_cout, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N:0] ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin, input logic sub);
    logic [N:0] r;
    if (sub) begin
      r[N-1:0] = a - b;
      r[N]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rnd256();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issues one request, then waits (bounded) for rsp_valid; returns latency in edges after accept.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub,
                        output int lat, output logic rr_low, output logic [7:0] cin_tr);
    int guard;
    @(negedge clock);
    req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    req_a = rnd256(); req_b = rnd256(); req_cin = $urandom_range(0, 1); req_sub = $urandom_range(0, 1);
    lat = 0;
    rr_low = !req_ready;
    cin_tr = '0;
    cin_tr[0] = add_cin;
    while (!rsp_valid && lat < 50) begin
      @(negedge clock);
      lat++;
      if (lat < 8) cin_tr[lat] = add_cin;
      if (req_ready) rr_low = 1'b0;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    total++;
    if ({req_ready, rsp_valid, rsp_cout, add_cin} !== 4'b1000) begin
      $display("FAIL reset_flags: got %b expected 1000", {req_ready, rsp_valid, rsp_cout, add_cin});
    end else passed++;
    total++;
    if (rsp_sum !== '0 || add_a !== '0 || add_b !== '0) begin
      $display("FAIL reset_data: sum %h add_a %h add_b %h expected zeros", rsp_sum, add_a, add_b);
    end else passed++;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL reset_release: req_ready %b rsp_valid %b expected 1 0", req_ready, rsp_valid);
    end else passed++;
  endtask

  task automatic test_basic();
    int lat; logic rr_low; logic [7:0] tr;
    run_op(256'd1, 256'd1, 1'b0, 1'b0, lat, rr_low, tr);
    total++;
    if (lat != 5) $display("FAIL basic_latency: got %0d expected 5", lat); else passed++;
    total++;
    if (rr_low !== 1'b1) $display("FAIL basic_req_ready_low: got %b expected 1", rr_low); else passed++;
    total++;
    if (rsp_sum !== 256'd2 || rsp_cout !== 1'b0)
      $display("FAIL basic_sum: got %h/%b expected %h/0", rsp_sum, rsp_cout, 256'd2);
    else passed++;
    consume();
  endtask

  task automatic test_carry_chain();
    int lat; logic rr_low; logic [7:0] tr;
    run_op({N{1'b1}}, '0, 1'b1, 1'b0, lat, rr_low, tr);
    total++;
    if (rsp_sum !== '0 || rsp_cout !== 1'b1)
      $display("FAIL carry_sum: got %h/%b expected 0/1", rsp_sum, rsp_cout);
    else passed++;
    total++;
    if (tr[3:0] !== 4'hf) $display("FAIL carry_add_cin: got %b expected 1111", tr[3:0]); else passed++;
    consume();
  endtask

  task automatic test_word_carry();
    int lat; logic rr_low; logic [7:0] tr;
    logic [N-1:0] exp_sum;
    exp_sum = '0;
    exp_sum[64] = 1'b1;
    run_op({{(N-64){1'b0}}, {64{1'b1}}}, 256'd1, 1'b0, 1'b0, lat, rr_low, tr);
    total++;
    if (rsp_sum !== exp_sum || rsp_cout !== 1'b0)
      $display("FAIL word_carry: got %h/%b expected %h/0", rsp_sum, rsp_cout, exp_sum);
    else passed++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat; logic rr_low; logic [7:0] tr;
    logic [N-1:0] a, b, held;
    logic c, held_c, stable;
    logic [N:0] exp;
    a = rnd256(); b = rnd256(); c = $urandom_range(0, 1);
    exp = ref_model(a, b, c, 1'b0);
    run_op(a, b, c, 1'b0, lat, rr_low, tr);
    total++;
    if ({rsp_cout, rsp_sum} !== exp)
      $display("FAIL bp_sum: got %h/%b expected %h/%b", rsp_sum, rsp_cout, exp[N-1:0], exp[N]);
    else passed++;
    held = rsp_sum; held_c = rsp_cout; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_sum !== held || rsp_cout !== held_c || req_ready !== 1'b0) stable = 1'b0;
    end
    total++;
    if (!stable) $display("FAIL bp_stable: got unstable outputs expected held result"); else passed++;
    consume();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_release: req_ready %b rsp_valid %b expected 1 0", req_ready, rsp_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [N:0] exp_q[$];
    logic [N:0] e;
    int issued, done, last_valid, change_next;
    issued = 0; done = 0; last_valid = -1; change_next = 0;
    rsp_ready = 1'b1;
    @(negedge clock);
    req_a = rnd256(); req_b = rnd256(); req_cin = $urandom_range(0, 1);
`ifdef MP_ADD_SUB_EN
    req_sub = $urandom_range(0, 1);
`else
    req_sub = 1'b0;
`endif
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && done < 8; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (rsp_valid) begin
        e = exp_q.pop_front();
        total++;
        if ({rsp_cout, rsp_sum} !== e)
          $display("FAIL b2b_sum%0d: got %h/%b expected %h/%b", done, rsp_sum, rsp_cout, e[N-1:0], e[N]);
        else passed++;
        if (last_valid >= 0) begin
          total++;
          if (cyc - last_valid != 7) $display("FAIL b2b_period: got %0d expected 7", cyc - last_valid);
          else passed++;
        end
        last_valid = cyc;
        done++;
      end
      if (change_next != 0) begin
        req_a = rnd256(); req_b = rnd256(); req_cin = $urandom_range(0, 1);
`ifdef MP_ADD_SUB_EN
        req_sub = $urandom_range(0, 1);
`endif
        change_next = 0;
        if (issued >= 8) req_valid = 1'b0;
      end
      if (req_ready && req_valid && issued < 8) begin
        exp_q.push_back(ref_model(req_a, req_b, req_cin, req_sub));
        issued++;
        change_next = 1;
      end
    end
    total++;
    if (done != 8) $display("FAIL b2b_count: got %0d expected 8", done); else passed++;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run();
    int lat; logic rr_low; logic [7:0] tr;
    int guard;
    @(negedge clock);
    req_a = rnd256(); req_b = rnd256(); req_cin = 1'b1; req_sub = 1'b0; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_cout, add_cin} !== 4'b1000)
      $display("FAIL midreset_flags: got %b expected 1000", {req_ready, rsp_valid, rsp_cout, add_cin});
    else passed++;
    total++;
    if (rsp_sum !== '0 || add_a !== '0 || add_b !== '0)
      $display("FAIL midreset_data: sum %h add_a %h add_b %h expected zeros", rsp_sum, add_a, add_b);
    else passed++;
    @(negedge clock);
    reset = 1'b1;
    run_op(256'd3, 256'd4, 1'b0, 1'b0, lat, rr_low, tr);
    total++;
    if (lat != 5 || rsp_sum !== 256'd7 || rsp_cout !== 1'b0)
      $display("FAIL midreset_after: got lat %0d %h/%b expected 5 %h/0", lat, rsp_sum, rsp_cout, 256'd7);
    else passed++;
    consume();
  endtask

`ifdef MP_ADD_SUB_EN
  task automatic test_sub();
    int lat; logic rr_low; logic [7:0] tr;
    logic [N-1:0] exp_sum;
    exp_sum = {N{1'b1}} - 256'd1;
    run_op(256'd5, 256'd7, 1'b0, 1'b1, lat, rr_low, tr);
    total++;
    if (rsp_sum !== exp_sum || rsp_cout !== 1'b0)
      $display("FAIL sub_borrow: got %h/%b expected %h/0", rsp_sum, rsp_cout, exp_sum);
    else passed++;
    consume();
    run_op(256'd7, 256'd5, 1'b0, 1'b1, lat, rr_low, tr);
    total++;
    if (rsp_sum !== 256'd2 || rsp_cout !== 1'b1)
      $display("FAIL sub_noborrow: got %h/%b expected %h/1", rsp_sum, rsp_cout, 256'd2);
    else passed++;
    consume();
  endtask
`endif

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; req_sub = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_carry_chain();
    test_word_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MP_ADD_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
